div: RTL and testbench

- Multi-cycle 32-bit integer divider for the RISC-V M-extension execute stage.
- Implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm that produces one quotient bit per clock.
- Returns the result together with the destination register address it was issued with, so writeback can retire it.
- Exposes a busy flag so the pipeline can stall while a division is in flight.

---
 rtl/div.sv | 151 +++++++++++++++
 tb/tb_div.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency: ready_o rises 33 edges after the accept edge; a held start_i is re-accepted every 34 edges.
// No backpressure: start_i is ignored while busy_o is high or the result is being formed.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  reg_waddr_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rem_q;       // partial remainder
    logic [31:0] quo_q;       // dividend shifting out, quotient shifting in
    logic [31:0] dsor_q;      // magnitude of the divisor
    logic        rem_sel;     // 1: return remainder, 0: return quotient
    logic [4:0]  waddr_q;
    logic        q_neg;
    logic        r_neg;
    logic        dsor_zero;

    logic        load;
    logic        step;
    logic        finish;

    // Operand conditioning at accept. Signed ops are DIV/REM: funct3 1x0.
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    assign signed_op = op_i[2] & ~op_i[0];
    assign a_neg     = signed_op & dividend_i[31];
    assign b_neg     = signed_op & divisor_i[31];
    assign a_abs     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
    assign b_abs     = b_neg ? (~divisor_i + 32'd1) : divisor_i;

    // One restoring step: shift {rem, dividend} left and trial-subtract the divisor.
    logic [32:0] rem_sh;
    logic [32:0] trial;

    assign rem_sh = {rem_q, quo_q[31]};
    assign trial  = rem_sh - {1'b0, dsor_q};

    // Sign-corrected results. With a zero divisor the quotient stays all-ones.
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign quo_fix = (q_neg && !dsor_zero) ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = r_neg ? (~rem_q + 32'd1) : rem_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE so a held start waits one edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded controls and the busy flag.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy_o = 1'b0;
        case (state)
            IDLE: load = start_i;
            CALC: begin
                step   = 1'b1;
                busy_o = 1'b1;
            end
            DONE: begin
                finish = 1'b1;
                busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Iteration datapath: latch operands on accept, then one quotient bit per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dsor_q    <= 32'd0;
            rem_sel   <= 1'b0;
            waddr_q   <= 5'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dsor_zero <= 1'b0;
        end else if (load) begin
            cnt       <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= a_abs;
            dsor_q    <= b_abs;
            rem_sel   <= op_i[1];
            waddr_q   <= reg_waddr_i;
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            dsor_zero <= (divisor_i == 32'd0);
        end else if (step) begin
            cnt <= cnt + 5'd1;
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= rem_sh[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    // Result registers: ready pulses for one cycle, data holds until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_o    <= 32'd0;
            ready_o     <= 1'b0;
            reg_waddr_o <= 5'd0;
        end else begin
            ready_o <= finish;
            if (finish) begin
                result_o    <= rem_sel ? rem_fix : quo_fix;
                reg_waddr_o <= waddr_q;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk;
    logic        rst;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    div dut (
        .clk         (clk),
        .rst         (rst),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .reg_waddr_i (reg_waddr_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  wa;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour from the RISC-V M-extension definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? 32'd0 : 32'h8000_0000;
        end else if (!op[0]) begin
            r = op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end else begin
            r = op[1] ? (a % b) : (a / b);
        end
        return r;
    endfunction

    // Drive one request, push its expectation, and return just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input bit hold);
        exp_t e;
        @(negedge clk);
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        start_i     = 1'b1;
        e.res = ref_res(op, a, b);
        e.wa  = wa;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        if (!hold) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    // Wait (bounded) for the ready pulse, check latency and payload, then check the pulse drops.
    task automatic wait_result(input int elapsed);
        int   n;
        bit   got;
        exp_t e;
        n   = elapsed;
        got = 1'b0;
        while (!got && n < elapsed + 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) got = 1'b1;
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("latency", n, 33);
            check("busy_in_ready", {31'd0, busy_o}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", result_o, e.res);
                check("waddr", {27'd0, reg_waddr_o}, {27'd0, e.wa});
            end else begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", {31'd0, ready_o}, 32'd0);
    endtask

    // Count ready pulses over a window with no request pending.
    task automatic expect_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    logic [2:0]  t_op [12];
    logic [31:0] t_a  [12];
    logic [31:0] t_b  [12];

    initial begin
        rst         = 1'b0;
        start_i     = 1'b0;
        op_i        = 3'd0;
        dividend_i  = 32'd0;
        divisor_i   = 32'd0;
        reg_waddr_i = 5'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result_o, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);

        // DIVU 14/2 with start held from the first edge after release.
        @(negedge clk);
        op_i        = OP_DIVU;
        dividend_i  = 32'd14;
        divisor_i   = 32'd2;
        reg_waddr_i = 5'd1;
        start_i     = 1'b1;
        rst         = 1'b1;
        exp_q.push_back('{res: 32'd7, wa: 5'd1});
        @(posedge clk);
        #1;
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        wait_result(0);

        // Directed operand table.
        t_op[0]  = OP_DIV;  t_a[0]  = -32'sd14;      t_b[0]  = 32'd4;
        t_op[1]  = OP_REM;  t_a[1]  = -32'sd14;      t_b[1]  = 32'd4;
        t_op[2]  = OP_REMU; t_a[2]  = 32'd14;        t_b[2]  = 32'd4;
        t_op[3]  = OP_DIVU; t_a[3]  = 32'd123;       t_b[3]  = 32'd0;
        t_op[4]  = OP_DIV;  t_a[4]  = 32'd123;       t_b[4]  = 32'd0;
        t_op[5]  = OP_REM;  t_a[5]  = 32'd123;       t_b[5]  = 32'd0;
        t_op[6]  = OP_REMU; t_a[6]  = 32'd123;       t_b[6]  = 32'd0;
        t_op[7]  = OP_DIV;  t_a[7]  = 32'h8000_0000; t_b[7]  = 32'hFFFF_FFFF;
        t_op[8]  = OP_REM;  t_a[8]  = 32'h8000_0000; t_b[8]  = 32'hFFFF_FFFF;
        t_op[9]  = OP_DIV;  t_a[9]  = 32'd7;         t_b[9]  = -32'sd2;
        t_op[10] = OP_REM;  t_a[10] = 32'd7;         t_b[10] = -32'sd2;
        t_op[11] = OP_DIVU; t_a[11] = 32'hFFFF_FFFF; t_b[11] = 32'd3;

        for (int i = 0; i < 12; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 2), 1'b0);
            wait_result(0);
        end

        // New operands and a start pulse while busy must not disturb the operation.
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd9, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op_i        = OP_REM;
        dividend_i  = 32'd55;
        divisor_i   = 32'd7;
        reg_waddr_i = 5'd30;
        start_i     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        wait_result(6);
        expect_quiet("extra_ready_after_busy_start", 40);

        // Reset in the middle of a division.
        @(negedge clk);
        op_i        = OP_DIVU;
        dividend_i  = 32'd77;
        divisor_i   = 32'd7;
        reg_waddr_i = 5'd12;
        start_i     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_result", result_o, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("ready_after_reset", 50);
        check("busy_after_reset", {31'd0, busy_o}, 32'd0);

        // Recovery after reset.
        issue(OP_DIVU, 32'd100, 32'd7, 5'd31, 1'b0);
        wait_result(0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
